// File: rtl/md_scheduler_if.sv
// Issue/operand/result bundle between the pipeline and the HI/LO multiply-divide scheduler.
// Pipeline side uses master; the scheduler uses slave.
interface md_scheduler_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_use_md;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, d_use_md,
        input  busy, md_stall, hi, lo
    );

    modport slave (
        input  start, op, a, b, d_use_md,
        output busy, md_stall, hi, lo
    );
endinterface

// File: rtl/md_scheduler.sv
// HI/LO mult/div scheduler: result is computed at issue, then held for MUL_CYC/DIV_CYC busy cycles before commit.
// MTHI/MTLO write in one cycle; the divider exists only when MD_DIV_EN is defined.
module md_scheduler #(
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic        clk,
    input  logic        rst,
    md_scheduler_if.slave md
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [3:0] MUL_CNT  = 4'(MUL_CYC);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYC);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] pend_hi, pend_lo;
    logic [31:0] hi_q, lo_q;

    logic        mul_op, div_op, long_op, sgn;
    logic [63:0] prod;
    logic [31:0] res_hi, res_lo;

    assign mul_op  = (md.op == OP_MULT) || (md.op == OP_MULTU);
    assign long_op = mul_op || div_op;
    // Even opcodes of each pair (MULT, DIV) are the signed forms.
    assign sgn     = ~md.op[0];
    assign prod    = {{32{sgn & md.a[31]}}, md.a} * {{32{sgn & md.b[31]}}, md.b};

`ifdef MD_DIV_EN
    logic        neg_a, neg_b;
    logic [31:0] ua, ub, quo_u, rem_u;

    assign div_op = (md.op == 3'd2) || (md.op == 3'd3);
    assign neg_a  = sgn & md.a[31];
    assign neg_b  = sgn & md.b[31];
    assign ua     = neg_a ? -md.a : md.a;
    assign ub     = neg_b ? -md.b : md.b;
    // Magnitude division sidesteps the 0x80000000 / -1 overflow; remainder follows the dividend.
    assign quo_u  = (ub == 32'd0) ? 32'd0 : ua / ub;
    assign rem_u  = (ub == 32'd0) ? 32'd0 : ua % ub;
`else
    assign div_op = 1'b0;
`endif

    always_comb begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
`ifdef MD_DIV_EN
        if (div_op) begin
            if (md.b == 32'd0) begin
                res_hi = hi_q;
                res_lo = lo_q;
            end else begin
                res_hi = neg_a ? -rem_u : rem_u;
                res_lo = (neg_a ^ neg_b) ? -quo_u : quo_u;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (md.start) begin
                        if (long_op) begin
                            state   <= BUSY;
                            cnt     <= mul_op ? MUL_CNT : DIV_CNT;
                            pend_hi <= res_hi;
                            pend_lo <= res_lo;
                        end else if (md.op == OP_MTHI) begin
                            hi_q <= md.a;
                        end else if (md.op == OP_MTLO) begin
                            lo_q <= md.a;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        hi_q  <= pend_hi;
                        lo_q  <= pend_lo;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign md.busy     = (state == BUSY);
    assign md.md_stall = rst & md.d_use_md & ((state == BUSY) | (md.start & long_op));
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;
endmodule
